// File: rtl/wfg_stim_sweep_ctrl.sv
// Frequency-sweep sequencer for the sine stimulus core: steps the angular increment
// from start to stop, holding each value for a programmed number of accepted stream samples.
module wfg_stim_sweep_ctrl #(
    parameter int INCW   = 16,
    parameter int DWELLW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_en_q_i,
    input  logic [1:0]        ctrl_mode_q_i,
    input  logic [INCW-1:0]   start_val_q_i,
    input  logic [INCW-1:0]   stop_val_q_i,
    input  logic [INCW-1:0]   step_val_q_i,
    input  logic [DWELLW-1:0] dwell_val_q_i,
    input  logic              axis_tvalid_i,
    input  logic              axis_tready_i,
    output logic [INCW-1:0]   inc_val_o,
    output logic              sine_en_o,
    output logic              step_pulse_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOOP = 2'd1;
    localparam logic [1:0] MODE_PING = 2'd2;

    state_t              state_q, state_d;
    logic [INCW-1:0]     cur_q, cur_d;
    logic [INCW-1:0]     target_q, target_d;
    logic                up_q, up_d;
    logic [DWELLW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic                pulse_d;

    logic [INCW-1:0]     start_q, stop_q, step_q;
    logic [DWELLW-1:0]   dwell_last_q;
    logic [1:0]          mode_q;

    logic                busy_q, done_q, pulse_q;
    logic                load;
    logic                accept;

    // One step toward the target in INCW+1 bits so overshoot and wrap both clamp to target.
    function automatic logic [INCW-1:0] step_toward(
        input logic [INCW-1:0] cur,
        input logic [INCW-1:0] step,
        input logic [INCW-1:0] target,
        input logic            up
    );
        logic [INCW:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, step};
            return (nxt > {1'b0, target}) ? target : nxt[INCW-1:0];
        end else begin
            nxt = {1'b0, cur} - {1'b0, step};
            return (nxt[INCW] || (nxt < {1'b0, target})) ? target : nxt[INCW-1:0];
        end
    endfunction

    assign load   = (state_q == IDLE) && ctrl_en_q_i;
    assign accept = axis_tvalid_i && axis_tready_i;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cur_d       = cur_q;
        target_d    = target_q;
        up_d        = up_q;
        dwell_cnt_d = dwell_cnt_q;
        pulse_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctrl_en_q_i) begin
                    state_d     = RUN;
                    cur_d       = start_val_q_i;
                    target_d    = stop_val_q_i;
                    up_d        = (stop_val_q_i >= start_val_q_i);
                    dwell_cnt_d = '0;
                end
            end
            RUN: begin
                // Disable beats a same-cycle handshake: no advance on the way out.
                if (!ctrl_en_q_i) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (dwell_cnt_q == dwell_last_q) begin
                        dwell_cnt_d = '0;
                        if (cur_q != target_q) begin
                            cur_d   = step_toward(cur_q, step_q, target_q, up_q);
                            pulse_d = (cur_d != cur_q);
                        end else begin
                            case (mode_q)
                                MODE_LOOP: begin
                                    cur_d    = start_q;
                                    target_d = stop_q;
                                    up_d     = (stop_q >= start_q);
                                    pulse_d  = 1'b1;
                                end
                                MODE_PING: begin
                                    target_d = (target_q == stop_q) ? start_q : stop_q;
                                    up_d     = !up_q;
                                    cur_d    = step_toward(cur_q, step_q, target_d, up_d);
                                    pulse_d  = 1'b1;
                                end
                                default: state_d = DONE;
                            endcase
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELLW'(1);
                    end
                end
            end
            DONE: begin
                if (!ctrl_en_q_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            target_q    <= '0;
            up_q        <= 1'b1;
            dwell_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            up_q        <= up_d;
            dwell_cnt_q <= dwell_cnt_d;
            busy_q      <= (state_d == RUN);
            done_q      <= (state_d == DONE);
            pulse_q     <= pulse_d;
        end
    end

    // Configuration snapshot, taken only on IDLE -> RUN so mid-sweep writes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_last_q <= '0;
            mode_q       <= '0;
        end else if (load) begin
            start_q      <= start_val_q_i;
            stop_q       <= stop_val_q_i;
            step_q       <= step_val_q_i;
            dwell_last_q <= (dwell_val_q_i == '0) ? '0 : dwell_val_q_i - DWELLW'(1);
            mode_q       <= ctrl_mode_q_i;
        end
    end

    assign inc_val_o    = cur_q;
    assign sine_en_o    = busy_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign step_pulse_o = pulse_q;

endmodule

// File: tb/tb_wfg_stim_sweep_ctrl.sv
// Scoreboard bench for wfg_stim_sweep_ctrl: stimulus queues the expected output events,
// a monitor pops and compares them as the DUT starts, steps, finishes or aborts.
module tb_wfg_stim_sweep_ctrl;

    localparam int INCW   = 16;
    localparam int DWELLW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ctrl_en_q_i;
    logic [1:0]        ctrl_mode_q_i;
    logic [INCW-1:0]   start_val_q_i, stop_val_q_i, step_val_q_i;
    logic [DWELLW-1:0] dwell_val_q_i;
    logic              axis_tvalid_i, axis_tready_i;
    logic [INCW-1:0]   inc_val_o;
    logic              sine_en_o, step_pulse_o, busy_o, done_o;

    always #5 clk = ~clk;

    wfg_stim_sweep_ctrl #(.INCW(INCW), .DWELLW(DWELLW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_en_q_i   (ctrl_en_q_i),
        .ctrl_mode_q_i (ctrl_mode_q_i),
        .start_val_q_i (start_val_q_i),
        .stop_val_q_i  (stop_val_q_i),
        .step_val_q_i  (step_val_q_i),
        .dwell_val_q_i (dwell_val_q_i),
        .axis_tvalid_i (axis_tvalid_i),
        .axis_tready_i (axis_tready_i),
        .inc_val_o     (inc_val_o),
        .sine_en_o     (sine_en_o),
        .step_pulse_o  (step_pulse_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    typedef enum logic [1:0] {EV_START, EV_STEP, EV_DONE, EV_ABORT} ev_kind_t;
    typedef struct packed {
        ev_kind_t        kind;
        logic [INCW-1:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [INCW-1:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("pending_events", exp_q.size(), 0);
    endtask

    task automatic cfg(input logic [INCW-1:0] s, input logic [INCW-1:0] p,
                       input logic [INCW-1:0] st, input logic [DWELLW-1:0] d,
                       input logic [1:0] m);
        start_val_q_i = s;
        stop_val_q_i  = p;
        step_val_q_i  = st;
        dwell_val_q_i = d;
        ctrl_mode_q_i = m;
    endtask

    // Monitor: classify each cycle's observable event and compare against the queue head.
    logic     prev_busy = 1'b0;
    logic     prev_done = 1'b0;
    initial begin
        ev_kind_t kind;
        logic     got;
        ev_t      e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                got  = 1'b1;
                kind = EV_STEP;
                if (done_o && !prev_done)                   kind = EV_DONE;
                else if (step_pulse_o)                      kind = EV_STEP;
                else if (busy_o && !prev_busy)              kind = EV_START;
                else if (!busy_o && prev_busy && !done_o)   kind = EV_ABORT;
                else                                        got  = 1'b0;
                if (got) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_event: got kind %0d value 0x%0h, expected none (t=%0t)",
                                 kind, inc_val_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_kind", 32'(kind), 32'(e.kind));
                        check("ev_inc_val", 32'(inc_val_o), 32'(e.val));
                        if (kind == EV_DONE || kind == EV_ABORT)
                            check("ev_sine_en_off", 32'(sine_en_o), 32'd0);
                    end
                end
                prev_busy = busy_o;
                prev_done = done_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        rst_n = 1'b0;
        ctrl_en_q_i = 1'b0;
        axis_tvalid_i = 1'b0;
        axis_tready_i = 1'b0;
        cfg(16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
        #12;
        check("rst_inc_val",  32'(inc_val_o), 32'd0);
        check("rst_sine_en",  32'(sine_en_o), 32'd0);
        check("rst_pulse",    32'(step_pulse_o), 32'd0);
        check("rst_busy",     32'(busy_o), 32'd0);
        check("rst_done",     32'(done_o), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single up sweep, dwell 2, continuous handshakes.
        cfg(16'd100, 16'd130, 16'd10, 16'd2, 2'd0);
        axis_tvalid_i = 1'b1;
        axis_tready_i = 1'b1;
        expect_ev(EV_START, 16'd100);
        expect_ev(EV_STEP,  16'd110);
        expect_ev(EV_STEP,  16'd120);
        expect_ev(EV_STEP,  16'd130);
        expect_ev(EV_DONE,  16'd130);
        ctrl_en_q_i = 1'b1;
        tick(8);
        check("single_not_done_after_7", 32'(done_o), 32'd0);
        tick(1);
        check("single_done_after_8", 32'(done_o), 32'd1);
        check("single_sine_en_off", 32'(sine_en_o), 32'd0);
        drain(5);
        ctrl_en_q_i = 1'b0;
        tick(1);
        check("single_leave_done", 32'(done_o), 32'd0);
        check("single_idle_inc_held", 32'(inc_val_o), 32'd130);
        tick(1);

        // Down sweep with clamp at the stop value; mode 3 behaves as single.
        cfg(16'd50, 16'd10, 16'd15, 16'd1, 2'd3);
        expect_ev(EV_START, 16'd50);
        expect_ev(EV_STEP,  16'd35);
        expect_ev(EV_STEP,  16'd20);
        expect_ev(EV_STEP,  16'd10);
        expect_ev(EV_DONE,  16'd10);
        ctrl_en_q_i = 1'b1;
        drain(20);
        ctrl_en_q_i = 1'b0;
        tick(2);

        // Ping-pong, then abort together with a handshake.
        cfg(16'd0, 16'd20, 16'd10, 16'd1, 2'd2);
        expect_ev(EV_START, 16'd0);
        expect_ev(EV_STEP,  16'd10);
        expect_ev(EV_STEP,  16'd20);
        expect_ev(EV_STEP,  16'd10);
        expect_ev(EV_STEP,  16'd0);
        expect_ev(EV_STEP,  16'd10);
        expect_ev(EV_STEP,  16'd20);
        expect_ev(EV_STEP,  16'd10);
        expect_ev(EV_ABORT, 16'd10);
        ctrl_en_q_i = 1'b1;
        tick(8);
        check("ping_never_done", 32'(done_o), 32'd0);
        ctrl_en_q_i = 1'b0;
        tick(1);
        check("abort_busy_off", 32'(busy_o), 32'd0);
        check("abort_inc_held", 32'(inc_val_o), 32'd10);
        drain(5);
        tick(1);

        // Dwell of 3 gated by tready toggling; a mid-sweep stop write must be ignored.
        cfg(16'd200, 16'd230, 16'd10, 16'd3, 2'd0);
        axis_tvalid_i = 1'b1;
        axis_tready_i = 1'b0;
        expect_ev(EV_START, 16'd200);
        expect_ev(EV_STEP,  16'd210);
        expect_ev(EV_STEP,  16'd220);
        expect_ev(EV_STEP,  16'd230);
        expect_ev(EV_DONE,  16'd230);
        ctrl_en_q_i = 1'b1;
        tick(1);
        hs = 0;
        for (int c = 0; c < 100 && !done_o; c++) begin
            axis_tready_i = (c % 2 == 0);
            tick(1);
            if (axis_tready_i) begin
                hs++;
                if (hs == 2) check("dwell_hold_after_2", 32'(inc_val_o), 32'd200);
                if (hs == 3) begin
                    check("dwell_step_after_3", 32'(inc_val_o), 32'd210);
                    stop_val_q_i = 16'd999;
                end
            end
        end
        check("dwell_sweep_done", 32'(done_o), 32'd1);
        drain(5);
        ctrl_en_q_i = 1'b0;
        axis_tready_i = 1'b1;
        tick(2);

        // Loop mode with overflow clamp to 0xFFFF.
        cfg(16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 2'd1);
        expect_ev(EV_START, 16'hFFF0);
        expect_ev(EV_STEP,  16'hFFFF);
        expect_ev(EV_STEP,  16'hFFF0);
        expect_ev(EV_STEP,  16'hFFFF);
        expect_ev(EV_STEP,  16'hFFF0);
        expect_ev(EV_ABORT, 16'hFFF0);
        ctrl_en_q_i = 1'b1;
        tick(5);
        ctrl_en_q_i = 1'b0;
        tick(1);
        drain(5);
        tick(1);

        // Asynchronous reset mid-RUN while a step pulse is high.
        cfg(16'd5, 16'd100, 16'd1, 16'd1, 2'd0);
        expect_ev(EV_START, 16'd5);
        expect_ev(EV_STEP,  16'd6);
        expect_ev(EV_STEP,  16'd7);
        ctrl_en_q_i = 1'b1;
        tick(3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_inc_val", 32'(inc_val_o), 32'd0);
        check("async_rst_sine_en", 32'(sine_en_o), 32'd0);
        check("async_rst_pulse",   32'(step_pulse_o), 32'd0);
        check("async_rst_busy",    32'(busy_o), 32'd0);
        check("async_rst_done",    32'(done_o), 32'd0);
        ctrl_en_q_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("final_pending_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
